// File: rtl/apb_pkg.sv
// Shared types for the APB slave register file:
// FSM encoding, word-address shift and error-cause helper.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_t;

  localparam int APB_WORD_SHIFT = 2;

  function automatic logic apb_err_cause(
    input logic misalign,
    input logic range_err,
    input logic ro_write
  );
    return misalign | range_err | ro_write;
  endfunction

endpackage

// File: rtl/apb_regbank.sv
// Register storage for the APB slave: strobe-masked write,
// RO/RW read mux and flattened regs_o.
module apb_regbank
  import apb_pkg::*;
#(
  parameter int                   DATA_W    = 32,
  parameter int                   NUM_REGS  = 8,
  parameter int                   IDX_W     = 3,
  parameter logic [NUM_REGS-1:0]  RO_MASK   = '0,
  parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we,
  input  logic [IDX_W-1:0]           widx,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [DATA_W/8-1:0]        wstrb,
  input  logic [IDX_W-1:0]           ridx,
  input  logic [NUM_REGS*DATA_W-1:0] status_i,
  output logic [DATA_W-1:0]          rdata,
  output logic [NUM_REGS*DATA_W-1:0] regs_o
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_REGS; k++)
        mem[k] <= RESET_VAL;
    end else if (we) begin
      for (int k = 0; k < NUM_REGS; k++)
        for (int b = 0; b < NB; b++)
          if (widx == IDX_W'(k) && wstrb[b])
            mem[k][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  // RO slots never get written, so their storage simply holds RESET_VAL
  always_comb begin
    rdata = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (ridx == IDX_W'(k))
        rdata = RO_MASK[k] ? status_i[k*DATA_W +: DATA_W]
                           : mem[k];
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
    assign regs_o[g*DATA_W +: DATA_W] = mem[g];
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB slave register file with wait states and PSLVERR.
// Define APB_PSTRB_EN to add the pstrb byte-strobe port.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int                  ADDR_W      = 8,
  parameter int                  DATA_W      = 32,
  parameter int                  NUM_REGS    = 8,
  parameter int                  WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
  parameter logic [DATA_W-1:0]   RESET_VAL   = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [ADDR_W-1:0]          paddr,
  input  logic [DATA_W-1:0]          pwdata,
`ifdef APB_PSTRB_EN
  input  logic [DATA_W/8-1:0]        pstrb,
`endif
  output logic                       pready,
  output logic                       pslverr,
  output logic [DATA_W-1:0]          prdata,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  input  logic [NUM_REGS*DATA_W-1:0] status_i,
  output logic [1:0]                 state_o
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  apb_state_t        state, state_n;
  logic [3:0]        wcnt, wcnt_n;
  logic              cap, commit;
  logic [IDX_W-1:0]  idx_q;
  logic              wr_q, err_q;
  logic [DATA_W-1:0] wdata_q, rdata;
  logic [NB-1:0]     strb_q, strb_in;
  logic [31:0]       word;
  logic              misalign, out_rng, ro_hit, err_in;

`ifdef APB_PSTRB_EN
  assign strb_in = pstrb;
`else
  assign strb_in = '1;
`endif

  assign word     = 32'(paddr >> APB_WORD_SHIFT);
  assign misalign = paddr[1:0] != 2'b00;
  assign out_rng  = word >= 32'(NUM_REGS);

  always_comb begin
    ro_hit = 1'b0;
    for (int k = 0; k < NUM_REGS; k++)
      if (word == 32'(k))
        ro_hit = RO_MASK[k];
  end

  assign err_in = apb_err_cause(misalign, out_rng,
                                pwrite & ro_hit);

  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    cap     = 1'b0;
    commit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (psel && !penable) begin
          cap = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_n = ACCESS;
          end else begin
            state_n = SETUP;
            wcnt_n  = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      SETUP: begin
        if (!psel || !penable)
          state_n = IDLE;
        else if (wcnt == 4'd0)
          state_n = ACCESS;
        else
          wcnt_n = wcnt - 4'd1;
      end
      ACCESS: begin
        state_n = IDLE;
        commit  = psel && wr_q && !err_q;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      wcnt    <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      if (cap) begin
        idx_q   <= word[IDX_W-1:0];
        wr_q    <= pwrite;
        err_q   <= err_in;
        wdata_q <= pwdata;
        strb_q  <= strb_in;
      end
    end
  end

  apb_regbank #(
    .DATA_W    (DATA_W),
    .NUM_REGS  (NUM_REGS),
    .IDX_W     (IDX_W),
    .RO_MASK   (RO_MASK),
    .RESET_VAL (RESET_VAL)
  ) u_bank (
    .clk      (clk),
    .reset    (reset),
    .we       (commit),
    .widx     (idx_q),
    .wdata    (wdata_q),
    .wstrb    (strb_q),
    .ridx     (idx_q),
    .status_i (status_i),
    .rdata    (rdata),
    .regs_o   (regs_o)
  );

  assign pready  = state == ACCESS;
  assign pslverr = pready & err_q;
  assign prdata  = (pready && !wr_q && !err_q) ? rdata : '0;
  assign state_o = state;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: three instances (0/3/2 wait states,
// different RO masks) checked against an array-based register model.
module tb_apb_slave_regfile;

  localparam int ND = 3;
  localparam int NR = 8;
  localparam int WAITS [ND] = '{0, 3, 2};
  localparam logic [7:0] ROM [ND] = '{8'h80, 8'h06, 8'h00};
  localparam logic [31:0] RVAL [ND] =
    '{32'h0, 32'h0000_1234, 32'h0BAD_F00D};
`ifdef APB_PSTRB_EN
  localparam bit STRB_ON = 1'b1;
`else
  localparam bit STRB_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         psel    [ND];
  logic         penable [ND];
  logic         pwrite  [ND];
  logic [7:0]   paddr   [ND];
  logic [31:0]  pwdata  [ND];
`ifdef APB_PSTRB_EN
  logic [3:0]   pstrb   [ND];
`endif
  logic         pready  [ND];
  logic         pslverr [ND];
  logic [31:0]  prdata  [ND];
  logic [255:0] regs    [ND];
  logic [1:0]   st      [ND];
  logic [255:0] status;

  logic [31:0] mm [ND][NR];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    apb_slave_regfile #(
      .ADDR_W      (8),
      .DATA_W      (32),
      .NUM_REGS    (NR),
      .WAIT_CYCLES (WAITS[g]),
      .RO_MASK     (ROM[g]),
      .RESET_VAL   (RVAL[g])
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .psel     (psel[g]),
      .penable  (penable[g]),
      .pwrite   (pwrite[g]),
      .paddr    (paddr[g]),
      .pwdata   (pwdata[g]),
`ifdef APB_PSTRB_EN
      .pstrb    (pstrb[g]),
`endif
      .pready   (pready[g]),
      .pslverr  (pslverr[g]),
      .prdata   (prdata[g]),
      .regs_o   (regs[g]),
      .status_i (status),
      .state_o  (st[g])
    );
  end

  function automatic logic [31:0] stat_word(int k);
    return (k == 7) ? 32'h1234_5678 : 32'(32'hA000_0000 + k);
  endfunction

  function automatic logic [255:0] model_flat(int d);
    logic [255:0] f;
    for (int k = 0; k < NR; k++) f[k*32 +: 32] = mm[d][k];
    return f;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++)
      for (int k = 0; k < NR; k++) mm[d][k] = RVAL[d];
  endtask

  task automatic chk(input string nm, input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic bus_idle(input int d);
    psel[d] = 1'b0;
    penable[d] = 1'b0;
    pwrite[d] = 1'b0;
    paddr[d] = '0;
    pwdata[d] = '0;
`ifdef APB_PSTRB_EN
    pstrb[d] = 4'hF;
`endif
  endtask

  task automatic setup(input int d, input bit wr, input logic [7:0] a,
                       input logic [31:0] wd, input logic [3:0] sb);
    @(negedge clk);
    psel[d] = 1'b1;
    penable[d] = 1'b0;
    pwrite[d] = wr;
    paddr[d] = a;
    pwdata[d] = wd;
`ifdef APB_PSTRB_EN
    pstrb[d] = sb;
`else
    if (sb != 4'hF && STRB_ON) $display("strobe ignored");
`endif
  endtask

  task automatic xfer(input int d, input bit wr, input logic [7:0] a,
                      input logic [31:0] wd, input logic [3:0] sb,
                      output logic [31:0] rd, output logic er,
                      output int nw);
    nw = 0;
    setup(d, wr, a, wd, sb);
    @(negedge clk);
    penable[d] = 1'b1;
    while (pready[d] !== 1'b1 && nw < 40) begin
      @(negedge clk);
      nw++;
    end
    rd = prdata[d];
    er = pslverr[d];
    @(negedge clk);
    bus_idle(d);
  endtask

  task automatic run(input int d, input bit wr, input logic [7:0] a,
                     input logic [31:0] wd, input logic [3:0] sb,
                     output logic [31:0] rd, output logic er);
    int nw;
    int k;
    bit e_err;
    logic [31:0] e_rd;
    logic [3:0] es;
    k = a / 4;
    e_err = (a % 4) != 0;
    if (k >= NR) e_err = 1'b1;
    else if (wr && ROM[d][k]) e_err = 1'b1;
    e_rd = '0;
    if (!wr && !e_err) e_rd = ROM[d][k] ? stat_word(k) : mm[d][k];
    xfer(d, wr, a, wd, sb, rd, er, nw);
    chk($sformatf("waits u%0d a=%02h", d, a), nw, WAITS[d]);
    chk($sformatf("pslverr u%0d a=%02h", d, a), er, e_err);
    chk($sformatf("prdata u%0d a=%02h", d, a), rd, e_rd);
    if (wr && !e_err) begin
      es = STRB_ON ? sb : 4'hF;
      for (int b = 0; b < 4; b++)
        if (es[b]) mm[d][k][b*8 +: 8] = wd[b*8 +: 8];
    end
    for (int i = 0; i < ND; i++)
      chk($sformatf("regs_o u%0d", i), regs[i], model_flat(i));
  endtask

  typedef struct {
    int          d;
    bit          wr;
    logic [7:0]  a;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic er;
    int nw;
    int d;
    int r;
    logic [7:0] a;

    tbl[0]  = '{0, 1'b1, 8'h04, 32'hDEAD_BEEF, 1'b0, 32'h0};
    tbl[1]  = '{0, 1'b0, 8'h04, 32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[2]  = '{0, 1'b1, 8'h40, 32'h0123_4567, 1'b1, 32'h0};
    tbl[3]  = '{0, 1'b1, 8'h06, 32'h89AB_CDEF, 1'b1, 32'h0};
    tbl[4]  = '{0, 1'b0, 8'h1C, 32'h0,         1'b0, 32'h1234_5678};
    tbl[5]  = '{0, 1'b1, 8'h1C, 32'hCAFE_F00D, 1'b1, 32'h0};
    tbl[6]  = '{0, 1'b0, 8'h04, 32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[7]  = '{1, 1'b0, 8'h00, 32'h0,         1'b0, 32'h0000_1234};
    tbl[8]  = '{1, 1'b1, 8'h04, 32'h5555_5555, 1'b1, 32'h0};
    tbl[9]  = '{1, 1'b0, 8'h08, 32'h0,         1'b0, 32'hA000_0002};
    tbl[10] = '{1, 1'b0, 8'h20, 32'h0,         1'b1, 32'h0};
    tbl[11] = '{2, 1'b0, 8'h08, 32'h0,         1'b0, 32'h0BAD_F00D};

    for (int k = 0; k < NR; k++) status[k*32 +: 32] = stat_word(k);
    for (int i = 0; i < ND; i++) bus_idle(i);
    model_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("reset state u%0d", i), st[i], 2'b00);
      chk($sformatf("reset pready u%0d", i), pready[i], 1'b0);
      chk($sformatf("reset pslverr u%0d", i), pslverr[i], 1'b0);
      chk($sformatf("reset prdata u%0d", i), prdata[i], 32'h0);
      chk($sformatf("reset regs u%0d", i), regs[i], model_flat(i));
    end
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run(tbl[i].d, tbl[i].wr, tbl[i].a, tbl[i].wd, 4'hF, rd, er);
      chk($sformatf("tbl%0d err", i), er, tbl[i].err);
      chk($sformatf("tbl%0d rdata", i), rd, tbl[i].rd);
    end
    chk("u0 reg1 after write", regs[0][63:32], 32'hDEAD_BEEF);

`ifdef APB_PSTRB_EN
    run(0, 1'b1, 8'h04, 32'h1122_3344, 4'hF, rd, er);
    run(0, 1'b1, 8'h04, 32'hAABB_CCDD, 4'b0101, rd, er);
    chk("strobe merge", regs[0][63:32], 32'h11BB_33DD);
    run(0, 1'b1, 8'h04, 32'hFFFF_FFFF, 4'b0000, rd, er);
    chk("zero strobe err", er, 1'b0);
    chk("zero strobe data", regs[0][63:32], 32'h11BB_33DD);
`endif

    // psel dropped during a wait state: transfer abandoned
    setup(2, 1'b1, 8'h08, 32'hA5A5_A5A5, 4'hF);
    @(negedge clk);
    penable[2] = 1'b1;
    chk("abort in SETUP", st[2], 2'b01);
    chk("abort pready low", pready[2], 1'b0);
    @(negedge clk);
    bus_idle(2);
    @(negedge clk);
    chk("abort back to IDLE", st[2], 2'b00);
    chk("abort reg2 kept", regs[2][95:64], 32'h0BAD_F00D);

    // reset hitting an ACCESS cycle drops the pending write
    run(2, 1'b1, 8'h08, 32'h5555_AAAA, 4'hF, rd, er);
    setup(2, 1'b1, 8'h08, 32'hA5A5_A5A5, 4'hF);
    @(negedge clk);
    penable[2] = 1'b1;
    nw = 0;
    while (pready[2] !== 1'b1 && nw < 40) begin
      @(negedge clk);
      nw++;
    end
    chk("rst reached ACCESS", st[2], 2'b10);
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst state_o", st[2], 2'b00);
    chk("rst pready", pready[2], 1'b0);
    chk("rst reg2", regs[2][95:64], 32'h0BAD_F00D);
    for (int i = 0; i < ND; i++)
      chk($sformatf("rst regs u%0d", i), regs[i], model_flat(i));
    @(negedge clk);
    bus_idle(2);
    reset = 1'b0;

    for (int n = 0; n < 300; n++) begin
      d = $urandom_range(0, ND - 1);
      r = $urandom_range(0, 9);
      if (r < 7)
        a = 8'(4 * $urandom_range(0, NR - 1));
      else if (r == 7)
        a = 8'(4 * $urandom_range(0, NR - 1) + $urandom_range(1, 3));
      else
        a = 8'(8'h20 + 4 * $urandom_range(0, 55));
      run(d, 1'($urandom_range(0, 1)), a, $urandom,
          STRB_ON ? 4'($urandom_range(0, 15)) : 4'hF, rd, er);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- Parametrised APB slave with a register bank, programmable wait states and error response.
- Successor to the fixed IDLE/SETUP/ACCESS APB interface. Adds real address decode, PREADY wait-state insertion, PSLVERR generation and read-only status registers.
- Sits between the APB master/bridge and peripheral control logic. Control registers are driven out on regs_o; status is sampled from status_i.

Parameters:
- ADDR_W, 8: APB address width. Must be at least clog2(NUM_REGS)+2.
- DATA_W, 32: data width. Must be a multiple of 8.
- NUM_REGS, 8: number of word registers. Register k is at byte address 4*k.
- WAIT_CYCLES, 0: PREADY-low cycles inserted in every transfer, 0..15.
- RO_MASK, {NUM_REGS{1'b0}}: bit k=1 makes register k read-only. Reads return the status_i slice k.
- RESET_VAL, 0: reset value of every RW register.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- psel  in  1  APB select
- penable  in  1  APB enable
- pwrite  in  1  1=write, 0=read
- paddr  in  ADDR_W  byte address
- pwdata  in  DATA_W  write data
- pstrb  in  DATA_W/8  byte strobes (present only with APB_PSTRB_EN)
- pready  out  1  transfer completes this cycle
- pslverr  out  1  error response, valid only with pready
- prdata  out  DATA_W  read data, valid only with pready
- regs_o  out  NUM_REGS*DATA_W  flattened RW register contents; register k is at [k*DATA_W +: DATA_W]
- status_i  in  NUM_REGS*DATA_W  read-only register sources
- state_o  out  2  current FSM state (debug)

Behaviour:
- Reset (asynchronous): state=IDLE, wait counter=0, every RW register=RESET_VAL, pready=0, pslverr=0, prdata=0.
- FSM states, 2-bit encoding: IDLE=00, SETUP=01, ACCESS=10. state_o=state.
- IDLE, on an edge sampling psel=1 and penable=0:
  - latch paddr, pwrite, pwdata (and pstrb);
  - compute err = (paddr[1:0]!=0) | (paddr>>2 >= NUM_REGS) | (pwrite & RO_MASK[idx]);
  - go to ACCESS if WAIT_CYCLES==0; otherwise load wcnt=WAIT_CYCLES-1 and go to SETUP.
  - Any other input combination: stay in IDLE.
- SETUP: pready=0.
  - psel=0, or psel=1 with penable=0: abort to IDLE. No write, no response.
  - Otherwise: if wcnt==0 go to ACCESS, else decrement wcnt.
- ACCESS: pready=1, pslverr=err.
  - prdata = read data if the transfer is a read without error, else 0. Read data is the RW register value or the status_i slice, sampled in the ACCESS cycle.
  - On the edge leaving ACCESS: if pwrite=1 and err=0 and psel=1, write the latched data into register idx.
  - Next state is always IDLE. A back-to-back setup phase is the cycle after ACCESS and is captured from IDLE.
  - psel=0 during ACCESS: abort, no write, go to IDLE.
- Latency: every completed transfer has exactly WAIT_CYCLES wait cycles. pready rises in bus cycle 2+WAIT_CYCLES, counting the setup cycle as 1.
- Outside ACCESS, pready, pslverr and prdata are all 0.
- Error transfers never modify any register; pslverr=1 for one cycle alongside pready.
- Writes to RO registers and reads of out-of-range addresses both error. A read of an RO register succeeds.
- regs_o updates on the clock edge that commits the write.
- Reset asserted mid-transfer: immediate return to IDLE, outputs 0, registers back to RESET_VAL. The pending write is lost.

Optional Feature:
- APB_PSTRB_EN defined: the pstrb port exists. Only bytes with pstrb[b]=1 are written. A write with pstrb all zero completes without error and changes nothing.
- Undefined: no pstrb port; every write updates all bytes.

Decomposition:
- Package apb_pkg holds:
  - typedef enum logic [1:0] apb_state_t {IDLE, SETUP, ACCESS};
  - localparam APB_WORD_SHIFT=2;
  - an error-cause function taking misalign, range and ro_write.
- Sub-module apb_regbank: RW storage, strobe-masked write, RO/RW read mux, regs_o packing.
- The FSM and wait counter stay in apb_slave_regfile.

Test Plan:
- WAIT_CYCLES=0: write 0xDEADBEEF to 0x04, then read 0x04 -> pready high in the second bus cycle of each transfer, prdata=0xDEADBEEF, pslverr=0, regs_o[63:32]=0xDEADBEEF.
- WAIT_CYCLES=3: read 0x00 after reset -> exactly 3 pready=0 access cycles, then pready=1 with prdata=RESET_VAL.
- Write to 0x40 with NUM_REGS=8, then write to 0x06 -> pslverr=1 with pready on each, all registers unchanged.
- RO_MASK=8'h80 with status_i slice 7=0x12345678: read 0x1C -> 0x12345678, pslverr=0. Write 0x1C -> pslverr=1.
- WAIT_CYCLES=2, write 0xA5A5A5A5 to 0x08, drop psel during wait -> FSM back to IDLE, register 2 unchanged. Repeat with reset asserted in ACCESS -> state_o=00, register 2=RESET_VAL.
- APB_PSTRB_EN defined: register 1=0x11223344, write 0xAABBCCDD with pstrb=4'b0101 -> register 1=0x11BB33DD.
